// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types, BCD constants and BCD helpers for the alarm stage.
//   alarm_state_t : FSM state encoding, also driven out on alarm_unit.state
//   HOUR_MAX/MIN_MAX : BCD wrap points for hour and minute
//   RST_ALARM_*   : alarm time loaded on reset (07:00)
//   bcd2bin/bin2bcd/bcd_inc : two-digit BCD helpers
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZED  = 2'd3
    } alarm_state_t;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
    } bcd_hm_t;

    localparam logic [7:0] HOUR_MAX       = 8'h23;
    localparam logic [7:0] MIN_MAX        = 8'h59;
    localparam logic [7:0] RST_ALARM_HOUR = 8'h07;
    localparam logic [7:0] RST_ALARM_MIN  = 8'h00;

    // Two BCD digits (0..99) to binary.
    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return ({3'd0, b[7:4]} * 7'd10) + {3'd0, b[3:0]};
    endfunction

    // Binary 0..99 to two BCD digits.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // BCD +1 that wraps to 0x00 once the value reaches max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// bcd_time_add: combinational hh:mm + minutes in BCD.
//   hour, min   : BCD time in (hour 00..23, min 00..59)
//   add_min     : minutes to add, 0..59
//   carry_en    : 1 = minute overflow carries into the hour (hour wraps at 24),
//                 0 = hour passes through untouched (plain minute increment)
//   sum_hour/sum_min : wrapped BCD result
module bcd_time_add
    import alarm_pkg::*;
(
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [5:0] add_min,
    input  logic       carry_en,
    output logic [7:0] sum_hour,
    output logic [7:0] sum_min
);

    logic [6:0] min_sum;
    logic [6:0] min_wrap;
    logic [6:0] hour_bin;
    logic [6:0] hour_wrap;
    logic       carry;

    // add_min < 60, so one conditional subtract is enough to wrap the minute.
    always_comb begin
        min_sum   = bcd2bin(min) + {1'b0, add_min};
        carry     = (min_sum >= 7'd60);
        min_wrap  = carry ? (min_sum - 7'd60) : min_sum;
        hour_bin  = bcd2bin(hour) + {6'd0, carry};
        hour_wrap = (hour_bin >= 7'd24) ? 7'd0 : hour_bin;
        sum_min   = bin2bcd(min_wrap);
        sum_hour  = carry_en ? bin2bcd(hour_wrap) : hour;
    end

endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: alarm stage behind the BCD time counter.
//   clk, rst_n        : system clock, async active-low reset
//   hour/min/sec      : running BCD time
//   alarm_en          : level, arms the alarm
//   set_mode          : level, enables alarm time editing, blocks triggering
//   inc_hour/inc_min  : buttons, rising edge advances the stored alarm time
//   stop/snooze       : buttons, rising edge stops / snoozes the ring
//   alarm_hour/min    : stored alarm time (BCD)
//   ring              : registered buzzer enable, 1 s on / 1 s off while ringing
//   state             : FSM state (DISARMED/ARMED/RINGING/SNOOZED)
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic       alarm_en,
    input  logic       set_mode,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       stop,
    input  logic       snooze,
    output logic [7:0] alarm_hour,
    output logic [7:0] alarm_min,
    output logic       ring,
    output logic [1:0] state
);

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
    localparam logic [7:0] SNZ_LIMIT = 8'(MAX_SNOOZE);
    localparam logic [5:0] SNZ_ADD   = 6'(SNOOZE_MIN);

    // ---------------------------------------------------------------
    // Edge / tick detection
    // ---------------------------------------------------------------
    logic [7:0] sec_q;
    logic       inc_hour_q, inc_min_q, stop_q, snooze_q;
    logic       inc_hour_p, inc_min_p, stop_p, snooze_p;
    logic       tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q      <= 8'h00;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            stop_q     <= 1'b0;
            snooze_q   <= 1'b0;
        end else begin
            sec_q      <= sec;
            inc_hour_q <= inc_hour;
            inc_min_q  <= inc_min;
            stop_q     <= stop;
            snooze_q   <= snooze;
        end
    end

    assign inc_hour_p = inc_hour & ~inc_hour_q;
    assign inc_min_p  = inc_min  & ~inc_min_q;
    assign stop_p     = stop     & ~stop_q;
    assign snooze_p   = snooze   & ~snooze_q;
    // Any change of sec counts, so clock-adjust jumps are ticks too.
    assign tick       = (sec != sec_q);

    // ---------------------------------------------------------------
    // Alarm time storage
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hour <= RST_ALARM_HOUR;
            alarm_min  <= RST_ALARM_MIN;
        end else if (set_mode) begin
            if (inc_hour_p) alarm_hour <= bcd_inc(alarm_hour, HOUR_MAX);
            // Minute wraps on its own; never carries into the hour.
            if (inc_min_p)  alarm_min  <= bcd_inc(alarm_min, MIN_MAX);
        end
    end

    // ---------------------------------------------------------------
    // Snooze target = current time + SNOOZE_MIN
    // ---------------------------------------------------------------
    logic [7:0] snz_sum_hour, snz_sum_min;

    bcd_time_add u_snz_add (
        .hour     (hour),
        .min      (min),
        .add_min  (SNZ_ADD),
        .carry_en (1'b1),
        .sum_hour (snz_sum_hour),
        .sum_min  (snz_sum_min)
    );

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    alarm_state_t state_q, state_d;
    logic [7:0]   ring_cnt_q, ring_cnt_d;
    logic [7:0]   snooze_cnt_q, snooze_cnt_d;
    bcd_hm_t      snz_q, snz_d;
    logic         ring_d;
    logic         alarm_hit, snz_hit;

    assign alarm_hit = tick && (sec == 8'h00) && (hour == alarm_hour) && (min == alarm_min);
    assign snz_hit   = tick && (sec == 8'h00) && (hour == snz_q.hour) && (min == snz_q.min);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DISARMED;
            ring_cnt_q   <= 8'd0;
            snooze_cnt_q <= 8'd0;
            snz_q        <= '0;
            ring         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            snz_q        <= snz_d;
            ring         <= ring_d;
        end
    end

    // Branch order inside each state encodes event priority:
    // alarm_en, set_mode, stop, snooze, timeout, trigger.
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        snz_d        = snz_q;

        if (!alarm_en) begin
            state_d      = DISARMED;
            snooze_cnt_d = 8'd0;
        end else begin
            case (state_q)
                DISARMED: state_d = ARMED;
                ARMED: begin
                    if (!set_mode && alarm_hit) begin
                        state_d      = RINGING;
                        ring_cnt_d   = 8'd0;
                        snooze_cnt_d = 8'd0;
                    end
                end
                RINGING: begin
                    if (set_mode || stop_p) begin
                        state_d = ARMED;
                    end else if (snooze_p && (snooze_cnt_q < SNZ_LIMIT)) begin
                        state_d      = SNOOZED;
                        snooze_cnt_d = snooze_cnt_q + 8'd1;
                        snz_d.hour   = snz_sum_hour;
                        snz_d.min    = snz_sum_min;
                    end else if (tick) begin
                        if (ring_cnt_q == RING_LAST)
                            state_d = ARMED;
                        else
                            ring_cnt_d = ring_cnt_q + 8'd1;
                    end
                end
                SNOOZED: begin
                    if (set_mode || stop_p) begin
                        state_d = ARMED;
                    end else if (snz_hit) begin
                        state_d    = RINGING;
                        ring_cnt_d = 8'd0;
                    end
                end
                default: state_d = DISARMED;
            endcase
        end

        // Registered so ring follows the state it belongs to: on in even seconds.
        ring_d = (state_d == RINGING) && !ring_cnt_d[0];
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed test of alarm_unit with RING_SECS=4, SNOOZE_MIN=5,
// MAX_SNOOZE=3. Inputs change 1 ns after the rising edge; outputs are sampled
// at the same point, i.e. after the edge that consumed the inputs.
module tb_alarm_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hour = 8'h00, min = 8'h00, sec = 8'h00;
    logic       alarm_en = 1'b0, set_mode = 1'b0;
    logic       inc_hour = 1'b0, inc_min = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic [7:0] alarm_hour, alarm_min;
    logic       ring;
    logic [1:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    alarm_unit #(
        .RING_SECS  (4),
        .SNOOZE_MIN (5),
        .MAX_SNOOZE (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .alarm_en   (alarm_en),
        .set_mode   (set_mode),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .stop       (stop),
        .snooze     (snooze),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .ring       (ring),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hour = h; min = m; sec = s;
        cyc();
    endtask

    task automatic tap_hour(input int n);
        repeat (n) begin inc_hour = 1'b1; cyc(); inc_hour = 1'b0; cyc(); end
    endtask

    task automatic tap_min(input int n);
        repeat (n) begin inc_min = 1'b1; cyc(); inc_min = 1'b0; cyc(); end
    endtask

    // Step onto 23:58:00 from a different second so the trigger sees a tick.
    task automatic fire();
        set_time(8'h23, 8'h57, 8'h59);
        set_time(8'h23, 8'h58, 8'h00);
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_alarm_hour", alarm_hour, 8'h07);
        chk("rst_alarm_min",  alarm_min,  8'h00);
        chk("rst_state",      {6'd0, state}, 8'd0);
        chk("rst_ring",       {7'd0, ring},  8'd0);
        rst_n = 1'b1;
        cyc();

        // Alarm time editing
        set_mode = 1'b1;
        tap_hour(3);
        tap_min(2);
        chk("set_hour", alarm_hour, 8'h10);
        chk("set_min",  alarm_min,  8'h02);
        set_mode = 1'b0;
        tap_hour(1);
        tap_min(1);
        chk("locked_hour", alarm_hour, 8'h10);
        chk("locked_min",  alarm_min,  8'h02);

        // Trigger, ring pattern, auto-stop after 4 ticks
        alarm_en = 1'b1;
        cyc();
        chk("armed", {6'd0, state}, 8'd1);
        set_time(8'h10, 8'h01, 8'h59);
        chk("pre_trig_state", {6'd0, state}, 8'd1);
        hour = 8'h10; min = 8'h02; sec = 8'h00;
        #1;
        chk("ring_latency", {7'd0, ring}, 8'd0);
        cyc();
        chk("trig_state", {6'd0, state}, 8'd2);
        chk("trig_ring",  {7'd0, ring},  8'd1);
        cyc();
        chk("no_tick_ring", {7'd0, ring}, 8'd1);
        set_time(8'h10, 8'h02, 8'h01);
        chk("pat_s1", {7'd0, ring}, 8'd0);
        set_time(8'h10, 8'h02, 8'h02);
        chk("pat_s2", {7'd0, ring}, 8'd1);
        set_time(8'h10, 8'h02, 8'h03);
        chk("pat_s3", {7'd0, ring}, 8'd0);
        chk("pat_s3_state", {6'd0, state}, 8'd2);
        set_time(8'h10, 8'h02, 8'h04);
        chk("timeout_state", {6'd0, state}, 8'd1);
        chk("timeout_ring",  {7'd0, ring},  8'd0);

        // Move alarm to 23:58, exercising both wraps on the way
        set_mode = 1'b1;
        tap_hour(13);
        chk("hour_23", alarm_hour, 8'h23);
        tap_hour(1);
        chk("hour_wrap", alarm_hour, 8'h00);
        tap_hour(23);
        tap_min(57);
        chk("min_59", alarm_min, 8'h59);
        tap_min(1);
        chk("min_wrap", alarm_min, 8'h00);
        chk("min_wrap_no_carry", alarm_hour, 8'h23);
        tap_min(58);
        chk("min_58", alarm_min, 8'h58);
        set_mode = 1'b0;
        cyc();

        // Snooze across midnight: 23:58 + 5 -> 00:03
        fire();
        chk("ring_2358", {6'd0, state}, 8'd2);
        snooze = 1'b1; cyc();
        chk("snz1_state", {6'd0, state}, 8'd3);
        chk("snz1_ring",  {7'd0, ring},  8'd0);
        snooze = 1'b0; cyc();
        set_time(8'h00, 8'h02, 8'h59);
        chk("snz1_wait", {6'd0, state}, 8'd3);
        set_time(8'h00, 8'h03, 8'h00);
        chk("snz1_wake_state", {6'd0, state}, 8'd2);
        chk("snz1_wake_ring",  {7'd0, ring},  8'd1);

        // Second and third snooze, then a fourth that is ignored
        snooze = 1'b1; cyc(); snooze = 1'b0; cyc();
        chk("snz2_state", {6'd0, state}, 8'd3);
        set_time(8'h00, 8'h07, 8'h59);
        set_time(8'h00, 8'h08, 8'h00);
        chk("snz2_wake", {6'd0, state}, 8'd2);
        snooze = 1'b1; cyc(); snooze = 1'b0; cyc();
        chk("snz3_state", {6'd0, state}, 8'd3);
        set_time(8'h00, 8'h12, 8'h59);
        set_time(8'h00, 8'h13, 8'h00);
        chk("snz3_wake", {6'd0, state}, 8'd2);
        snooze = 1'b1; cyc(); snooze = 1'b0; cyc();
        chk("snz4_ignored_state", {6'd0, state}, 8'd2);
        chk("snz4_ignored_ring",  {7'd0, ring},  8'd1);
        stop = 1'b1; cyc(); stop = 1'b0; cyc();
        chk("stop_state", {6'd0, state}, 8'd1);
        chk("stop_ring",  {7'd0, ring},  8'd0);

        // stop and snooze together: stop wins
        fire();
        chk("ring_again", {6'd0, state}, 8'd2);
        stop = 1'b1; snooze = 1'b1; cyc();
        chk("stop_vs_snz", {6'd0, state}, 8'd1);
        stop = 1'b0; snooze = 1'b0; cyc();

        // alarm_en dropped mid-ring
        fire();
        alarm_en = 1'b0; cyc();
        chk("dis_state", {6'd0, state}, 8'd0);
        chk("dis_ring",  {7'd0, ring},  8'd0);
        alarm_en = 1'b1; cyc();
        chk("rearm", {6'd0, state}, 8'd1);

        // set_mode while ringing, and no trigger while editing
        fire();
        set_mode = 1'b1; cyc();
        chk("setm_ring_state", {6'd0, state}, 8'd1);
        fire();
        chk("setm_no_trig_state", {6'd0, state}, 8'd1);
        chk("setm_no_trig_ring",  {7'd0, ring},  8'd0);
        set_mode = 1'b0; cyc();

        // Asynchronous reset while ringing
        fire();
        chk("pre_rst_ring", {7'd0, ring}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ring",  {7'd0, ring},  8'd0);
        chk("async_rst_state", {6'd0, state}, 8'd0);
        chk("async_rst_hour",  alarm_hour, 8'h07);
        chk("async_rst_min",   alarm_min,  8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
Alarm stage that sits directly downstream of the digital clock counter. It consumes the running BCD hour/min/sec, holds a user-settable alarm time, and drives a ring output when the alarm time is reached. It also supports stop, limited snooze and a 1 s on / 1 s off beep pattern. The ring output joins the clock's hourly tweet at the buzzer driver.

Parameters:
RING_SECS, 60, seconds a ring lasts before auto-stop (1..255)
SNOOZE_MIN, 5, snooze interval in minutes (1..59)
MAX_SNOOZE, 3, number of snoozes allowed per alarm event

Ports:
clk  in  1  system clock; same clock as the time counters
rst_n  in  1  asynchronous active-low reset
hour  in  8  current hour, BCD 0x00..0x23
min  in  8  current minute, BCD 0x00..0x59
sec  in  8  current second, BCD 0x00..0x59
alarm_en  in  1  level: alarm armed when 1
set_mode  in  1  level: alarm time editing enabled
inc_hour  in  1  button level; each rising edge advances alarm hour
inc_min  in  1  button level; each rising edge advances alarm minute
stop  in  1  button level; a rising edge ends ringing or snooze
snooze  in  1  button level; a rising edge snoozes while ringing
alarm_hour  out  8  stored alarm hour, BCD
alarm_min  out  8  stored alarm minute, BCD
ring  out  1  buzzer enable
state  out  2  current FSM state, for display and debug

Behaviour:
Reset values:
- alarm_hour=0x07, alarm_min=0x00.
- state=DISARMED, ring=0.
- sec_q=0x00, all button-history flops=0.
- snooze_cnt=0, ring_cnt=0.
- snz_hour=0x00, snz_min=0x00.

Edge and boundary detection:
- Every button input is edge-detected using a registered previous value.
- Action pulses are internal and one clock wide.
- Second boundary (tick) = (sec != sec_q); sec_q is registered each cycle.

Setting alarm time:
- Only while set_mode=1; inc pulses are ignored while set_mode=0.
- inc_hour: BCD increment, 0x23 wraps to 0x00.
- inc_min: BCD increment, 0x59 wraps to 0x00, with no carry into the hour.
- Update is visible on the outputs the cycle after the edge.

FSM, encoding DISARMED=0, ARMED=1, RINGING=2, SNOOZED=3:
- alarm_en=0 in any state -> DISARMED next cycle. ring=0, snooze_cnt=0.
- DISARMED -> ARMED when alarm_en=1.
- set_mode=1 in RINGING or SNOOZED -> ARMED; ring drops.
- No trigger is taken while set_mode=1.
- ARMED -> RINGING when tick and sec==0x00 and hour==alarm_hour and min==alarm_min. On entry: ring_cnt=0, snooze_cnt=0.
- RINGING:
  - ring = ~ring_cnt[0], so the buzzer is on in the first second.
  - ring_cnt increments on each tick.
  - At the tick where ring_cnt==RING_SECS-1 -> ARMED.
  - stop edge -> ARMED.
  - snooze edge with snooze_cnt<MAX_SNOOZE -> SNOOZED. On this transition: snooze_cnt++, and (snz_hour,snz_min) = current (hour,min)+SNOOZE_MIN. The minute wraps at 60 with carry to the hour; the hour wraps at 24.
  - snooze edge with snooze_cnt==MAX_SNOOZE is ignored.
- SNOOZED -> RINGING when tick and sec==0x00 and hour==snz_hour and min==snz_min. On entry ring_cnt=0; snooze_cnt is kept.
- SNOOZED -> ARMED on a stop edge.

Priority of simultaneous events, highest first:
- alarm_en=0, then set_mode, then stop, then snooze, then ring timeout, then trigger.

Reset and timing rules:
- Reset asserted mid-ring: ring=0 immediately (asynchronous); the alarm time returns to 07:00.
- ring is registered. It rises one clock after the triggering tick is observed, i.e. the cycle after sec changes to 0x00.
- Jumps in the time inputs, such as clock adjust keys, count as ticks. A jump onto hh:mm:00 matching the alarm triggers.

Decomposition:
- Package alarm_pkg holds:
  - the state encoding as a 2-bit enum with DISARMED/ARMED/RINGING/SNOOZED;
  - the BCD constants 0x23 (hour max) and 0x59 (minute max);
  - the reset alarm constants 0x07 and 0x00.
- Sub-module bcd_time_add: combinational. Inputs are hour and min (BCD) and an addend in minutes. Outputs are the wrapped BCD hour and min.
- bcd_time_add is used for the snooze target and is reusable for BCD increment, with addend 1 and the hour path masked.

Test Plan:
- Reset, then set_mode=1 with 3 inc_hour edges and 2 inc_min edges -> alarm_hour=0x10, alarm_min=0x02. With set_mode=0, further inc edges leave both unchanged.
- alarm 0x10:0x02, alarm_en=1, time steps 10:01:59 -> 10:02:00 -> ring=1 the next cycle, state=2. Ring pattern is 1,0,1,0 per tick. With RING_SECS=4, state returns to 1 after the 4th tick.
- Ringing at 23:58:00, snooze edge with SNOOZE_MIN=5 -> state=3, snz target 00:03. At 00:03:00 ring restarts and state=2.
- Three snoozes then a 4th snooze edge -> ignored, stays RINGING. stop edge -> state=1, ring=0. stop and snooze on the same cycle -> ARMED.
- alarm_en dropped mid-ring -> state=0 and ring=0 next cycle. Matching time with set_mode=1 -> no trigger.
- Assert rst_n=0 while ringing -> ring=0 asynchronously, alarm 07:00, state=0.
